// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple-carry adder: STAGES slices of WIDTH/STAGES bits, one slice per register stage,
// valid/ready handshake with a global stall. Define PIPE_ADDER_SUB_EN to add the sub port (a - b).
module pipelined_ripple_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PIPE_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int SLICE_W = WIDTH / STAGES;

  if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("pipelined_ripple_adder: WIDTH must be >= 2 and a multiple of STAGES >= 1");
  end

  // One pipeline slot: operands travel with their partial sum so transactions never mix.
  typedef struct packed {
    logic             valid;
    logic             carry;
    logic             ovf;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] sum;
  } stage_t;

  stage_t stage_q  [STAGES];
  stage_t stage_d  [STAGES];
  stage_t stage_in [STAGES];
  stage_t entry;
  logic   sub_en;

`ifdef PIPE_ADDER_SUB_EN
  assign sub_en = sub;
`else
  assign sub_en = 1'b0;
`endif

  // Subtraction is folded in at the entry: b' = ~b, cin' = ~cin.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    entry       = '0;
    entry.valid = in_valid;
    if (in_valid) begin
      entry.carry = cin ^ sub_en;
      entry.op_a  = a;
      entry.op_b  = b ^ {WIDTH{sub_en}};
    end
  end

  assign stage_in[0] = entry;
  for (genvar s = 1; s < STAGES; s++) begin : g_link
    assign stage_in[s] = stage_q[s-1];
  end

  // Slice s adds bits [s*SLICE_W +: SLICE_W] using the carry registered by the previous stage.
  always_comb begin
    logic [SLICE_W:0] slice_sum;
    logic             msb_a;
    logic             msb_b;
    logic             msb_r;
    slice_sum = '0;
    msb_a     = 1'b0;
    msb_b     = 1'b0;
    msb_r     = 1'b0;
    for (int s = 0; s < STAGES; s++) begin
      slice_sum = {1'b0, stage_in[s].op_a[s*SLICE_W +: SLICE_W]}
                + {1'b0, stage_in[s].op_b[s*SLICE_W +: SLICE_W]}
                + {{SLICE_W{1'b0}}, stage_in[s].carry};
      stage_d[s]                          = stage_in[s];
      stage_d[s].sum[s*SLICE_W +: SLICE_W] = slice_sum[SLICE_W-1:0];
      stage_d[s].carry                    = slice_sum[SLICE_W];
    end
    msb_a = stage_d[STAGES-1].op_a[WIDTH-1];
    msb_b = stage_d[STAGES-1].op_b[WIDTH-1];
    msb_r = stage_d[STAGES-1].sum[WIDTH-1];
    stage_d[STAGES-1].ovf = ~(msb_a ^ msb_b) & (msb_r ^ msb_a);
  end

  assign in_ready = ~(out_valid & ~out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath is cleared along with the valid bits so the outputs read 0 after reset.
      for (int s = 0; s < STAGES; s++) stage_q[s] <= '0;
    end else if (in_ready) begin
      // NOTE: non-blocking assignments make every stage sample the pre-edge value of its predecessor.
      for (int s = 0; s < STAGES; s++) stage_q[s] <= stage_d[s];
    end
  end

  assign out_valid = stage_q[STAGES-1].valid;
  assign result    = stage_q[STAGES-1].sum;
  assign cout      = stage_q[STAGES-1].carry;
  assign overflow  = stage_q[STAGES-1].ovf;

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Directed self-checking bench for pipelined_ripple_adder (WIDTH=32, STAGES=4); results are
// checked in order against hand-computed {cout, overflow, result} values.
module tb_pipelined_ripple_adder;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef PIPE_ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;

  logic [33:0] exp_q [$];
  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  pipelined_ripple_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
`ifdef PIPE_ADDER_SUB_EN
    .sub      (sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] ta, input logic [31:0] tb, input logic tc);
    a        = ta;
    b        = tb;
    cin      = tc;
    in_valid = 1'b1;
  endtask

  task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic tc,
                      input logic [33:0] e);
    put(ta, tb, tc);
    exp_q.push_back(e);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
    repeat (2) step();
    check(tag, exp_q.size(), 0);
  endtask

  // Output monitor: a transfer happens at the next rising edge when valid and ready are both high.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) check("spurious_out", out_valid, 1'b0);
      else                   check("result", {cout, overflow, result}, exp_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] b2b_sum [8];
    logic [11:0] hist;
    b2b_sum = '{32'h00000000, 32'h11111113, 32'h22222224, 32'h33333337,
                32'h44444448, 32'h5555555B, 32'h6666666C, 32'h7777777F};
    hist    = '0;

    // Reset, with operands offered that must not be accepted.
    rst       = 1'b1;
    out_ready = 1'b1;
`ifdef PIPE_ADDER_SUB_EN
    sub       = 1'b0;
`endif
    put(32'h11, 32'h22, 1'b1);
    repeat (3) step();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result",    result,    32'h0);
    check("rst_cout",      cout,      1'b0);
    check("rst_overflow",  overflow,  1'b0);
    check("rst_in_ready",  in_ready,  1'b1);
    rst = 1'b0;
    idle();
    drain("rst_no_accept");

    // Wrap-around and latency.
    send(32'hFFFFFFFF, 32'h00000001, 1'b0, {1'b1, 1'b0, 32'h00000000});
    step();
    idle();
    check("lat_edge0", out_valid, 1'b0);
    step();
    check("lat_edge1", out_valid, 1'b0);
    step();
    check("lat_edge2", out_valid, 1'b0);
    step();
    check("lat_edge3", out_valid, 1'b1);
    drain("lat_drain");

    // Signed overflow corners.
    send(32'h7FFFFFFF, 32'h00000001, 1'b0, {1'b0, 1'b1, 32'h80000000});
    step();
    send(32'h80000000, 32'h80000000, 1'b0, {1'b1, 1'b1, 32'h00000000});
    step();
    idle();
    drain("ovf_drain");

    // Eight back-to-back transactions.
    for (int c = 0; c < 12; c++) begin
      if (c < 8) begin
        logic [31:0] i_v;
        i_v = c;
        send(i_v, i_v * 32'h11111111, i_v[0], {1'b0, 1'b0, b2b_sum[c]});
      end else begin
        idle();
      end
      step();
      hist[c] = out_valid;
      check("b2b_in_ready", in_ready, 1'b1);
    end
    check("b2b_valid_run", hist, 12'h7F8);
    drain("b2b_drain");

    // Fill the pipeline, then stall the consumer for five cycles.
    out_ready = 1'b0;
    send(32'h0000FFFF, 32'h00000001, 1'b0, {1'b0, 1'b0, 32'h00010000});
    step();
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, {1'b1, 1'b0, 32'hFFFFFFFF});
    step();
    send(32'h12345678, 32'h11111111, 1'b0, {1'b0, 1'b0, 32'h23456789});
    step();
    send(32'h00FF00FF, 32'h00010001, 1'b1, {1'b0, 1'b0, 32'h01000101});
    step();
    put(32'hDEADBEEF, 32'h0BADF00D, 1'b1);
    for (int j = 0; j < 5; j++) begin
      check("stall_in_ready",  in_ready,  1'b0);
      check("stall_out_valid", out_valid, 1'b1);
      check("stall_result",    result,    32'h00010000);
      check("stall_cout",      cout,      1'b0);
      step();
    end
    out_ready = 1'b1;
    idle();
    drain("stall_drain");

    // Reset with three transactions in flight.
    put(32'h00000001, 32'h00000002, 1'b0);
    step();
    put(32'h00000003, 32'h00000004, 1'b0);
    step();
    put(32'h00000005, 32'h00000006, 1'b1);
    step();
    rst = 1'b1;
    idle();
    step();
    rst = 1'b0;
    check("flush_in_ready", in_ready, 1'b1);
    for (int j = 0; j < 4; j++) begin
      step();
      check("flush_out_valid", out_valid, 1'b0);
    end
    send(32'hAAAAAAAA, 32'h55555555, 1'b1, {1'b1, 1'b0, 32'h00000000});
    step();
    idle();
    drain("flush_drain");

`ifdef PIPE_ADDER_SUB_EN
    sub = 1'b1;
    send(32'h00000005, 32'h00000007, 1'b0, {1'b0, 1'b0, 32'hFFFFFFFE});
    step();
    send(32'h00000007, 32'h00000005, 1'b0, {1'b1, 1'b0, 32'h00000002});
    step();
    sub = 1'b0;
    idle();
    drain("sub_drain");
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pipelined_ripple_adder.md
PIPELINED_RIPPLE_ADDER -- requirements
Module: pipelined_ripple_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: operand and result width in bits, minimum 2.
REQ-002 The block SHALL have parameter STAGES, default 4: number of pipeline register stages; WIDTH SHALL be an integer multiple of STAGES, and STAGES SHALL be at least 1.
REQ-003 The block SHALL have clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have in_valid, input, 1 bit: operands present.
REQ-006 The block SHALL have in_ready, output, 1 bit: block can accept operands this cycle.
REQ-007 The block SHALL have a and b, inputs, WIDTH bits each: operands.
REQ-008 The block SHALL have cin, input, 1 bit: carry-in.
REQ-009 The block SHALL have sub, input, 1 bit: subtract request; present only when PIPE_ADDER_SUB_EN is defined.
REQ-010 The block SHALL have out_valid, output, 1 bit: result presented.
REQ-011 The block SHALL have out_ready, input, 1 bit: consumer takes the result this cycle.
REQ-012 The block SHALL have result, output, WIDTH bits: sum.
REQ-013 The block SHALL have cout, output, 1 bit: carry out of the MSB.
REQ-014 The block SHALL have overflow, output, 1 bit: two's-complement signed overflow.

Function
REQ-015 The carry chain SHALL be split into STAGES slices of WIDTH/STAGES bits, LSB slice first, with one ripple-carry slice per stage and a registered carry passed into the next slice.
REQ-016 Operand bits not yet consumed SHALL be carried forward in the pipeline alongside each transaction, and result bits already produced SHALL likewise travel with it, so that slices of one transaction never mix with another.
REQ-017 A transaction SHALL be accepted on a rising edge where in_valid and in_ready are both 1.
REQ-018 in_ready SHALL equal NOT(out_valid AND NOT out_ready), combinationally; all stages advance together exactly when in_ready is 1 (global stall).
REQ-019 Bubbles SHALL propagate as invalid stages and SHALL NOT be collapsed.
REQ-020 A transaction accepted at edge k SHALL be presented with out_valid=1 immediately after edge k+STAGES-1, giving a latency of STAGES edges.
REQ-021 Throughput SHALL be one transaction per cycle while out_ready is held at 1.
REQ-022 While out_valid=1 and out_ready=0, result, cout, overflow and out_valid SHALL hold stable, and no transaction SHALL be accepted, lost or duplicated.
REQ-023 The final outputs SHALL be {cout,result} = a + b' + cin' mod 2^(WIDTH+1), where b'=b and cin'=cin when not subtracting.
REQ-024 overflow SHALL be (a[MSB] XNOR b'[MSB]) AND (result[MSB] != a[MSB]).
REQ-025 When in_valid=0 at an edge with in_ready=1, a bubble SHALL enter stage 1.
REQ-026 When out_valid=0, out_ready SHALL have no effect.

Reset
REQ-027 While rst=1 at a rising edge, all stage valid bits SHALL clear to 0 and out_valid, result, cout and overflow SHALL be 0 from the next cycle.
REQ-028 Reset mid-operation SHALL discard all in-flight transactions, and no stale result SHALL ever appear after reset.
REQ-029 in_ready SHALL be 1 after reset.
REQ-030 Operands presented during a reset cycle SHALL NOT be accepted.

Configuration
REQ-031 The macro PIPE_ADDER_SUB_EN SHALL control subtraction; when defined, port sub exists and is captured with the operands, and sub=1 SHALL give b' = ~b and cin' = NOT cin, so that with cin=0 the result is a-b and cout=1 means no borrow.
REQ-032 When PIPE_ADDER_SUB_EN is undefined, port sub SHALL be absent and the block SHALL be add-only, with behaviour identical to sub=0.

Verification (WIDTH=32, STAGES=4)
REQ-033 The bench SHALL apply a=0xFFFFFFFF, b=0x00000001, cin=0, with out_ready=1 -> result 0x00000000, cout 1, overflow 0, out_valid exactly 4 edges after acceptance.
REQ-034 The bench SHALL apply a=0x7FFFFFFF, b=0x00000001, cin=0 -> result 0x80000000, cout 0, overflow 1; and a=0x80000000, b=0x80000000 -> result 0, cout 1, overflow 1.
REQ-035 The bench SHALL apply 8 back-to-back transactions a=i, b=i*0x11111111, cin=i[0] for i=0..7 -> 8 consecutive out_valid cycles with in-order correct sums, and in_ready held at 1 throughout.
REQ-036 The bench SHALL fill the pipeline, then hold out_ready=0 for 5 cycles -> in_ready 0, outputs frozen, and after release all 4 results emerge once, in order.
REQ-037 The bench SHALL assert rst for 1 cycle with 3 transactions in flight -> out_valid stays 0 for the following 4 cycles, and the next accepted transaction returns the correct result.
REQ-038 With PIPE_ADDER_SUB_EN defined, the bench SHALL apply sub=1, a=5, b=7, cin=0 -> result 0xFFFFFFFE, cout 0; and sub=1, a=7, b=5 -> result 2, cout 1.
